// File: rtl/reg64_write_arbiter_pkg.sv
// Shared types and width helpers for the
// 64-bit register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_ACK_L = 2'd2,
    S_OWNED = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reg64_write_arbiter_if.sv
// Writer-side bundle of the register arbiter:
// requests, lock hints, data, grants and status.
interface reg64_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
);
  localparam int OWN_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         reg_q;
  logic [OWN_W-1:0]          owner;
  logic                      busy;
  logic                      locked;

  modport master (
    output req,
    output req_lock,
    output req_data,
    input  gnt,
    input  reg_q,
    input  owner,
    input  busy,
    input  locked
  );

  modport slave (
    input  req,
    input  req_lock,
    input  req_data,
    output gnt,
    output reg_q,
    output owner,
    output busy,
    output locked
  );

endinterface

// File: rtl/reg64_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or
// after ptr, wrapping modulo N.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from farthest to nearest so the
  // closest hit to ptr is the last one kept.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = IW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg64_write_arbiter.sv
// Owns one shared register; round-robin writers
// with optional bounded lock bursts.
module reg64_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 4
) (
  input  logic clk,
  input  logic reset,
  reg64_write_arbiter_if.slave bus
);

  localparam int OWN_W = idx_w(NUM_REQ);
  localparam int CW    = cnt_w(MAX_LOCK);

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [DATA_W-1:0]   reg_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [OWN_W-1:0]    owner_q;
  logic [OWN_W-1:0]    rr_q;
  logic [CW-1:0]       cnt_q;

  logic                wr;
  logic [OWN_W-1:0]    wr_idx;
  logic [OWN_W-1:0]    rr_next;
  logic [OWN_W-1:0]    pick_idx;
  logic                pick_found;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OWN_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    wr_idx  = pick_idx;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          wr = 1'b1;
          if (bus.req_lock[pick_idx] && MAX_LOCK > 1)
            state_d = S_ACK_L;
          else
            state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ACK_L: state_d = S_OWNED;
      S_OWNED: begin
        wr_idx = owner_q;
        if (bus.req[owner_q]) begin
          wr = 1'b1;
          if (bus.req_lock[owner_q] &&
              int'(cnt_q) + 1 < MAX_LOCK)
            state_d = S_ACK_L;
          else
            state_d = S_ACK;
        end else if (!bus.req_lock[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rr_next =
    (wr_idx == OWN_W'(NUM_REQ - 1)) ?
    '0 : wr_idx + OWN_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      reg_q   <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= '0;
      if (wr) begin
        reg_q   <= bus.req_data[int'(wr_idx)*DATA_W +: DATA_W];
        gnt_q   <= NUM_REQ'(1) << wr_idx;
        owner_q <= wr_idx;
        // Pointer only advances on fresh arbitration;
        // during a burst it already points past owner.
        if (state_q == S_IDLE) begin
          rr_q  <= rr_next;
          cnt_q <= CW'(1);
        end else if (cnt_q < CW'(MAX_LOCK)) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.reg_q  = reg_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.locked = (state_q == S_ACK_L) ||
                      (state_q == S_OWNED);

endmodule

// File: tb/tb_reg64_write_arbiter.sv
// Randomized and directed checks of the register
// arbiter against a transaction-level model.
module tb_reg64_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg64_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  reg64_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .MAX_LOCK(ML)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: free=arbitrate, cool=mandatory gap after a
  // write, held=one writer owns the register.
  int       phase_free;
  int       cool_then_held;
  int       cooling;
  int       holder;
  int       burst;
  int       m_ptr;
  int       m_owner;
  logic [W-1:0] m_reg;
  logic [N-1:0] m_gnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cooling = 0; cool_then_held = 0; holder = -1;
    burst = 0; m_ptr = 0; m_owner = 0;
    m_reg = '0; m_gnt = '0;
  endtask

  task automatic do_write(input int w);
    m_reg   = bus.req_data[w*W +: W];
    m_gnt   = N'(1) << w;
    m_owner = w;
  endtask

  task automatic model_edge();
    int w;
    m_gnt = '0;
    if (cooling != 0) begin
      cooling = 0;
      if (cool_then_held == 0) holder = -1;
    end else if (holder < 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        do_write(w);
        m_ptr = (w + 1) % N;
        burst = 1;
        cooling = 1;
        holder = w;
        cool_then_held = (bus.req_lock[w] && ML > 1) ? 1 : 0;
      end
    end else if (bus.req[holder]) begin
      do_write(holder);
      if (burst < ML) burst++;
      cooling = 1;
      cool_then_held = (bus.req_lock[holder] && burst < ML) ? 1 : 0;
    end else if (!bus.req_lock[holder]) begin
      holder = -1;
    end
  endtask

  task automatic check_all();
    logic is_busy, is_locked;
    is_busy   = (cooling != 0) || (holder >= 0);
    is_locked = (cooling != 0) ? (cool_then_held != 0) : (holder >= 0);
    chk("gnt", 64'(bus.gnt), 64'(m_gnt));
    chk("reg_q", bus.reg_q, m_reg);
    chk("owner", 64'(bus.owner), 64'(m_owner));
    chk("busy", 64'(bus.busy), 64'(is_busy));
    chk("locked", 64'(bus.locked), 64'(is_locked));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_reg", bus.reg_q, 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_lock = '0;
    bus.req_data = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    for (int i = 0; i < N; i++)
      bus.req_data[i*W +: W] = {32'hDEAD_BEEF, 32'(i)};

    // Reset while ACK is in progress
    bus.req = 4'b0001;
    cycle();
    chk("t1_gnt", 64'(bus.gnt), 64'(1));
    bus.req = '0;
    pulse_reset();

    // Single writer
    bus.req = 4'b0100;
    cycle();
    chk("t2_gnt", 64'(bus.gnt), 64'(4));
    chk("t2_reg", bus.reg_q, 64'hDEAD_BEEF_0000_0002);
    chk("t2_own", 64'(bus.owner), 64'(2));
    bus.req = '0;
    cycle();
    chk("t2_gnt0", 64'(bus.gnt), 64'(0));
    chk("t2_busy", 64'(bus.busy), 64'(0));

    // Strict rotation
    pulse_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_rot", 64'(bus.gnt), 64'(1) << (k % N));
      cycle();
      chk("t3_gap", 64'(bus.gnt), 64'(0));
    end
    bus.req = '0;
    cycle();

    // Lock burst capped at ML writes
    pulse_reset();
    bus.req = 4'b0011;
    bus.req_lock = 4'b0001;
    for (int k = 0; k < ML; k++) begin
      cycle();
      chk("t4_lk", 64'(bus.gnt), 64'(1));
      cycle();
    end
    chk("t4_unlk", 64'(bus.locked), 64'(0));
    cycle();
    chk("t4_g1", 64'(bus.gnt), 64'(2));
    bus.req = '0;
    bus.req_lock = '0;
    cycle();

    // Non-owner blocked, then release to pending req3
    pulse_reset();
    bus.req = 4'b0010;
    bus.req_lock = 4'b0010;
    cycle();
    chk("t6_g1", 64'(bus.gnt), 64'(2));
    bus.req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t6_blk", 64'(bus.gnt), 64'(0));
    end
    chk("t6_lkd", 64'(bus.locked), 64'(1));
    bus.req = 4'b1000;
    bus.req_lock = '0;
    cycle();
    chk("t5_idle", 64'(bus.busy), 64'(0));
    cycle();
    chk("t5_g3", 64'(bus.gnt), 64'(8));
    chk("t5_reg", bus.reg_q, 64'hDEAD_BEEF_0000_0003);
    bus.req = '0;
    cycle();

    // Random writers
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
          else bus.req_data[i*W +: W] = {$urandom, $urandom};
        end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[i*W +: W] = {$urandom, $urandom};
        end
        if ($urandom_range(3, 0) == 0) bus.req_lock[i] = ~bus.req_lock[i];
      end
      if ($urandom_range(99, 0) == 0) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
